// File: rtl/sobel_window_sequencer.sv
// Walks the frame buffer one 3x3 neighbourhood per interior pixel and presents it to the Sobel core.
// Latency: 9 read cycles + RD_LAT drain cycles + 1 present cycle per window when unstalled.
// Backpressure: win_ready low freezes the presented window; hold high pauses read issue only.
module sobel_window_sequencer #(
  parameter int WIDTH  = 250,
  parameter int HEIGHT = 250,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic        rd_en,
  output logic [7:0]  rd_addr_r,
  output logic [7:0]  rd_addr_c,
  input  logic [7:0]  rd_data,
  output logic [71:0] win_data,
  output logic [7:0]  win_row,
  output logic [7:0]  win_col,
  output logic        win_valid,
  input  logic        win_ready
);

  localparam logic [7:0] LAST_R = 8'(HEIGHT - 2);
  localparam logic [7:0] LAST_C = 8'(WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  r, c, r_nxt, c_nxt;
  logic [3:0]  k, k_nxt, k_base;
  logic [3:0]  cap_cnt;
  logic [3:0]  rd_k;
  logic [1:0]  dr, dc;
  logic        win_start;
  logic        issue;
  logic        cap;
  logic        tag_vld [RD_LAT];
  logic [3:0]  tag_k   [RD_LAT];

  assign cap = tag_vld[RD_LAT-1];

  // Next-state, target advance and read-issue decisions.
  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    c_nxt     = c;
    win_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          r_nxt     = 8'd1;
          c_nxt     = 8'd1;
          win_start = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (k == 4'd9) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((cap_cnt + {3'b000, cap}) == 4'd9) state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (win_ready) begin
          if (r == LAST_R && c == LAST_C) begin
            state_nxt = S_DONE;
          end else begin
            win_start = 1'b1;
            state_nxt = S_FETCH;
            if (c == LAST_C) begin
              c_nxt = 8'd1;
              r_nxt = r + 8'd1;
            end else begin
              c_nxt = c + 8'd1;
            end
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // A new window restarts the read index at 0 in the same cycle it is entered.
    k_base = win_start ? 4'd0 : k;
    issue  = !hold && (win_start || (state == S_FETCH && k != 4'd9));
    k_nxt  = issue ? k_base + 4'd1 : k_base;

    dr = 2'd0;
    dc = 2'd0;
    case (k_base)
      4'd0:    begin dr = 2'd0; dc = 2'd0; end
      4'd1:    begin dr = 2'd0; dc = 2'd1; end
      4'd2:    begin dr = 2'd0; dc = 2'd2; end
      4'd3:    begin dr = 2'd1; dc = 2'd0; end
      4'd4:    begin dr = 2'd1; dc = 2'd1; end
      4'd5:    begin dr = 2'd1; dc = 2'd2; end
      4'd6:    begin dr = 2'd2; dc = 2'd0; end
      4'd7:    begin dr = 2'd2; dc = 2'd1; end
      4'd8:    begin dr = 2'd2; dc = 2'd2; end
      default: begin dr = 2'd0; dc = 2'd0; end
    endcase
  end

  // State, target coordinate and read index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      r     <= 8'd0;
      c     <= 8'd0;
      k     <= 4'd0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      c     <= c_nxt;
      k     <= k_nxt;
    end
  end

  // Buffer read port: one strobe per issued neighbourhood pixel, address held while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr_r <= 8'd0;
      rd_addr_c <= 8'd0;
      rd_k      <= 4'd0;
    end else if (issue) begin
      rd_en     <= 1'b1;
      rd_addr_r <= r_nxt - 8'd1 + {6'd0, dr};
      rd_addr_c <= c_nxt - 8'd1 + {6'd0, dc};
      rd_k      <= k_base;
    end else begin
      rd_en     <= 1'b0;
    end
  end

  // Tag pipeline matching the buffer latency so each returning byte knows its window slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_k[i]   <= 4'd0;
      end
    end else begin
      tag_vld[0] <= rd_en;
      tag_k[0]   <= rd_k;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_k[i]   <= tag_k[i-1];
      end
    end
  end

  // Capture returning bytes into the window and count them so DRAIN knows when it is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_data <= 72'd0;
      cap_cnt  <= 4'd0;
    end else begin
      if (cap) win_data[{tag_k[RD_LAT-1], 3'b000} +: 8] <= rd_data;
      if (win_start)  cap_cnt <= 4'd0;
      else if (cap)   cap_cnt <= cap_cnt + 4'd1;
    end
  end

  // Presented window handshake, target coordinate and pass status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_row   <= 8'd0;
      win_col   <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      win_valid <= (state_nxt == S_PRESENT);
      if (state == S_DRAIN && state_nxt == S_PRESENT) begin
        win_row <= r;
        win_col <= c;
      end
      busy <= (state_nxt == S_FETCH) || (state_nxt == S_DRAIN) || (state_nxt == S_PRESENT);
      done <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_sobel_window_sequencer.sv
module tb_sobel_window_sequencer;

  localparam int W1 = 4, H1 = 4;
  localparam int W3 = 7, H3 = 6;

  logic        clk = 1'b0;
  logic        rst_n, start, hold, win_ready;
  logic        busy, done, rd_en, win_valid;
  logic [7:0]  rd_addr_r, rd_addr_c, rd_data, win_row, win_col;
  logic [71:0] win_data;

  logic        start3, hold3, win_ready3;
  logic        busy3, done3, rd_en3, win_valid3;
  logic [7:0]  rd_addr_r3, rd_addr_c3, rd_data3, win_row3, win_col3;
  logic [71:0] win_data3;
  logic [7:0]  d3_a, d3_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  sobel_window_sequencer #(.WIDTH(W1), .HEIGHT(H1), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_r(rd_addr_r), .rd_addr_c(rd_addr_c), .rd_data(rd_data),
    .win_data(win_data), .win_row(win_row), .win_col(win_col),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  sobel_window_sequencer #(.WIDTH(W3), .HEIGHT(H3), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .hold(hold3), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr_r(rd_addr_r3), .rd_addr_c(rd_addr_c3), .rd_data(rd_data3),
    .win_data(win_data3), .win_row(win_row3), .win_col(win_col3),
    .win_valid(win_valid3), .win_ready(win_ready3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Frame content: pixel(r,c) = 16r + c.
  function automatic logic [7:0] pix(input int r, input int c);
    return 8'(16 * r + c);
  endfunction

  // Expected window: pixel k = 3*dy+dx taken from (r-1+dy, c-1+dx).
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[8*k +: 8] = pix(r - 1 + k / 3, c - 1 + k % 3);
    return w;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame buffer models with latency 1 and 3.
  always @(posedge clk) begin
    if (rd_en) rd_data <= pix(int'(rd_addr_r), int'(rd_addr_c));
    d3_a     <= pix(int'(rd_addr_r3), int'(rd_addr_c3));
    d3_b     <= d3_a;
    rd_data3 <= d3_b;
  end

  // Scoreboard for the 4x4 instance.
  int win_idx, rd_cnt, done_cnt, first_rd, pres0, done_cyc, stall_cnt;
  logic        prev_valid = 1'b0, prev_stall = 1'b0;
  logic [71:0] prev_data;
  logic [7:0]  prev_row, prev_col;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin
        win_idx = 0; rd_cnt = 0; done_cnt = 0; first_rd = -1; pres0 = -1; stall_cnt = 0;
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        rd_cnt++;
        check("addr_r_in_range", 72'(rd_addr_r < 8'(H1)), 72'd1);
        check("addr_c_in_range", 72'(rd_addr_c < 8'(W1)), 72'd1);
      end
      if (win_valid) begin
        if (prev_stall) begin
          check("stall_data_stable", win_data, prev_data);
          check("stall_row_stable", 72'(win_row), 72'(prev_row));
          check("stall_col_stable", 72'(win_col), 72'(prev_col));
        end
        if (!prev_valid && win_idx == 0) pres0 = cyc;
        if (win_ready) begin
          check("win_row", 72'(win_row), 72'(1 + win_idx / (W1 - 2)));
          check("win_col", 72'(win_col), 72'(1 + win_idx % (W1 - 2)));
          check("win_data", win_data, exp_win(1 + win_idx / (W1 - 2), 1 + win_idx % (W1 - 2)));
          if (win_idx == 0) check("win11_literal", win_data, 72'h222120121110020100);
          check("reads_per_window", 72'(rd_cnt), 72'd9);
          rd_cnt = 0;
          win_idx++;
        end else begin
          stall_cnt++;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", 72'(busy), 72'd0);
      end
      prev_valid = win_valid;
      prev_stall = win_valid && !win_ready;
      prev_data  = win_data;
      prev_row   = win_row;
      prev_col   = win_col;
    end
  end

  // Scoreboard for the 7x6, latency-3 instance under random backpressure.
  int win3_idx = 0, done3_cnt = 0;
  logic        prev3_stall = 1'b0;
  logic [71:0] prev3_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en3) begin
        check("addr3_r_in_range", 72'(rd_addr_r3 < 8'(H3)), 72'd1);
        check("addr3_c_in_range", 72'(rd_addr_c3 < 8'(W3)), 72'd1);
      end
      if (win_valid3) begin
        if (prev3_stall) check("stall3_data_stable", win_data3, prev3_data);
        if (win_ready3) begin
          check("win3_row", 72'(win_row3), 72'(1 + win3_idx / (W3 - 2)));
          check("win3_col", 72'(win_col3), 72'(1 + win3_idx % (W3 - 2)));
          check("win3_centre", 72'(win_data3[39:32]), 72'(pix(int'(win_row3), int'(win_col3))));
          check("win3_data", win_data3, exp_win(1 + win3_idx / (W3 - 2), 1 + win3_idx % (W3 - 2)));
          win3_idx++;
        end
      end
      if (done3) done3_cnt++;
      prev3_stall = win_valid3 && !win_ready3;
      prev3_data  = win_data3;
    end
  end

  // Random acceptance for the latency-3 instance.
  initial begin
    win_ready3 = 1'b1;
    forever begin
      @(posedge clk);
      #1 win_ready3 = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      72'(busy),      72'd0);
    check({tag, "_done"},      72'(done),      72'd0);
    check({tag, "_rd_en"},     72'(rd_en),     72'd0);
    check({tag, "_rd_addr_r"}, 72'(rd_addr_r), 72'd0);
    check({tag, "_rd_addr_c"}, 72'(rd_addr_c), 72'd0);
    check({tag, "_win_data"},  win_data,       72'd0);
    check({tag, "_win_row"},   72'(win_row),   72'd0);
    check({tag, "_win_col"},   72'(win_col),   72'd0);
    check({tag, "_win_valid"}, 72'(win_valid), 72'd0);
  endtask

  // Pulse start; returns just after the edge that samples it and checks the first read.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (!hold) begin
      check("first_rd_en", 72'(rd_en), 72'd1);
      check("first_addr", 72'({rd_addr_r, rd_addr_c}), 72'h0000);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_seen_in_time", 72'(done_cnt > 0), 72'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_idx(input int idx, input int budget);
    int n = 0;
    while (win_idx < idx && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("window_reached_in_time", 72'(win_idx >= idx), 72'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!win_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("valid_in_time", 72'(win_valid), 72'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; win_ready = 1'b1;
    start3 = 1'b0; hold3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset");
    check("reset3_valid", 72'(win_valid3), 72'd0);
    check("reset3_busy", 72'(busy3), 72'd0);
    check("model_pin_11", exp_win(1, 1), 72'h222120121110020100);
    check("model_pin_22", exp_win(2, 2), 72'h333231232221131211);
    @(negedge clk) rst_n = 1'b1;

    // Baseline pass, with a start pulse mid-pass that must be ignored.
    pulse_start();
    repeat (15) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200);
    check("base_windows", 72'(win_idx), 72'd4);
    check("base_done_once", 72'(done_cnt), 72'd1);
    check("base_done_latency", 72'(done_cyc - first_rd), 72'd44);
    check("base_present_latency", 72'(pres0 - first_rd), 72'd10);
    check("base_no_stall", 72'(stall_cnt), 72'd0);
    check("idle_after_done", 72'(busy), 72'd0);

    // Window 2 held off for 5 cycles.
    pulse_start();
    wait_idx(1, 100);
    @(posedge clk);
    #1 win_ready = 1'b0;
    wait_valid(100);
    repeat (5) @(posedge clk);
    #1 win_ready = 1'b1;
    wait_done(200);
    check("stall_windows", 72'(win_idx), 72'd4);
    check("stall_done_once", 72'(done_cnt), 72'd1);
    check("stall_cycles", 72'(stall_cnt), 72'd5);
    check("stall_done_latency", 72'(done_cyc - first_rd), 72'd49);

    // hold raised for 3 cycles after the 4th read of window 1.
    pulse_start();
    repeat (3) @(posedge clk);
    #1 hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    wait_done(200);
    check("hold_windows", 72'(win_idx), 72'd4);
    check("hold_present_latency", 72'(pres0 - first_rd), 72'd13);
    check("hold_done_latency", 72'(done_cyc - first_rd), 72'd47);

    // Reset while window 2 is presented, then restart.
    pulse_start();
    wait_idx(1, 100);
    @(posedge clk);
    #1 win_ready = 1'b0;
    wait_valid(100);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    win_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("no_done_after_reset", 72'(done_cnt), 72'd0);
    check("no_resume_busy", 72'(busy), 72'd0);
    check("no_resume_valid", 72'(win_valid), 72'd0);
    pulse_start();
    wait_done(200);
    check("restart_windows", 72'(win_idx), 72'd4);
    check("restart_done_latency", 72'(done_cyc - first_rd), 72'd44);

    // Latency-3 instance with random backpressure.
    @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    n = 0;
    while (done3_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("lat3_done_once", 72'(done3_cnt), 72'd1);
    check("lat3_windows", 72'(win3_idx), 72'((W3 - 2) * (H3 - 2)));
    check("lat3_idle", 72'(busy3), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
